cvxif_issue_responder: RTL and testbench

// - Coprocessor-side end of the CVXIF issue/writeback path. Accepts offloaded instructions from the core's issue stage via valid/ready.
// - Buffers them in order, executes a small custom-0 opcode set and returns one writeback per accepted instruction: result, trans_id, rd write-enable, exception.
// - Sits beside ex_stage; its result port drives the core's CVXIF writeback slot (wt_valid/x_we/ex).

---
 rtl/cvxif_resp_pkg.sv | 69 ++++++
 rtl/fifo_v3.sv | 53 +++++
 rtl/cvxif_issue_responder.sv | 158 +++++++++++++++
 tb/tb_cvxif_issue_responder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_resp_pkg.sv
// Shared constants, types and decode helpers for the CVXIF issue responder.
// Optional feature macro: CVXIF_RESP_MUL_EN (CMUL opcode, multiplier and EXEC state).
package cvxif_resp_pkg;

   localparam int unsigned     XLEN           = 64;
   localparam int unsigned     TRANS_ID_BITS  = 3;
   localparam logic [6:0]      CUSTOM0_OPCODE = 7'b0001011;
   localparam logic [XLEN-1:0] ILLEGAL_INSTR  = XLEN'(2);

   typedef enum logic [2:0] {
      CADD = 3'b000,
      CNOP = 3'b001,
      CMUL = 3'b010
   } resp_op_e;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

   typedef struct packed {
      logic [31:0]              instr;
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [XLEN-1:0]          rs1;
      logic [XLEN-1:0]          rs2;
   } resp_entry_t;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic            we;
      exception_t      ex;
   } resp_result_t;

`ifdef CVXIF_RESP_MUL_EN
   typedef enum logic [1:0] {IDLE, EXEC, RESP} resp_state_e;
`else
   typedef enum logic [0:0] {IDLE, RESP} resp_state_e;
`endif

   function automatic logic is_custom0(logic [31:0] instr);
      return (instr[6:0] == CUSTOM0_OPCODE) && (instr[31:25] == 7'b0);
   endfunction

`ifdef CVXIF_RESP_MUL_EN
   function automatic logic is_cmul(logic [31:0] instr);
      return is_custom0(instr) && (instr[14:12] == CMUL);
   endfunction
`endif

   // Single-cycle ops; anything not handled here (including CMUL) is illegal.
   function automatic resp_result_t exec_single(logic [31:0] instr, logic [XLEN-1:0] rs1,
                                                logic [XLEN-1:0] rs2);
      resp_result_t r;
      r = '0;
      if (is_custom0(instr) && (instr[14:12] == CADD)) begin
         r.data = rs1 + rs2;
         r.we   = 1'b1;
      end else if (is_custom0(instr) && (instr[14:12] == CNOP)) begin
         r.we   = 1'b0;
      end else begin
         r.ex.valid = 1'b1;
         r.ex.cause = ILLEGAL_INSTR;
         r.ex.tval  = XLEN'(instr);
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with flush; push ignored when full, pop ignored when empty.
module fifo_v3 #(
   parameter int unsigned DEPTH = 4,
   parameter type         dtype = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   output logic full_o,
   output logic empty_o,
   input  dtype data_i,
   input  logic push_i,
   output dtype data_o,
   input  logic pop_i
);

   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dtype              mem_q [DEPTH];
   logic [ADDR_W-1:0] rd_q, wr_q;
   logic [ADDR_W:0]   cnt_q;
   logic              push_ok, pop_ok;

   assign full_o  = (cnt_q == (ADDR_W+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rd_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Pointer and occupancy bookkeeping; flush drops everything including a concurrent push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + ADDR_W'(1);
         if (pop_ok)  rd_q <= rd_q + ADDR_W'(1);
         if (push_ok && !pop_ok)      cnt_q <= cnt_q + (ADDR_W+1)'(1);
         else if (!push_ok && pop_ok) cnt_q <= cnt_q - (ADDR_W+1)'(1);
      end
   end

   // Storage array, written on accepted pushes only.
   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/cvxif_issue_responder.sv
// CVXIF coprocessor issue/writeback responder: buffers offloaded custom-0
// instructions in order and returns one writeback per accepted instruction.
// Optional feature macro: CVXIF_RESP_MUL_EN (shift-add CMUL, EXEC state).
module cvxif_issue_responder
   import cvxif_resp_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH         = 4,
   parameter int unsigned MUL_BITS_PER_CYCLE = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     x_issue_valid_i,
   output logic                     x_issue_ready_o,
   input  logic [31:0]              x_off_instr_i,
   input  logic [TRANS_ID_BITS-1:0] x_trans_id_i,
   input  logic [XLEN-1:0]          x_rs1_i,
   input  logic [XLEN-1:0]          x_rs2_i,
   output logic                     x_result_valid_o,
   output logic [TRANS_ID_BITS-1:0] x_result_id_o,
   output logic [XLEN-1:0]          x_result_data_o,
   output logic                     x_result_we_o,
   output exception_t               x_result_ex_o
);

   resp_entry_t              push_entry, head, cur_q, src;
   logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic                     pend_q, valid_q;
   logic [TRANS_ID_BITS-1:0] id_q;
   resp_result_t             res_q;
   resp_state_e              state_q;

`ifdef CVXIF_RESP_MUL_EN
   localparam int unsigned MUL_CYCLES = XLEN / MUL_BITS_PER_CYCLE;
   localparam int unsigned CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   logic [XLEN-1:0]  mcand_q, mplier_q, acc_q, acc_next;
   logic [CNT_W-1:0] cnt_q;

   // One shift-add step: multiplicand times the low multiplier digit.
   always_comb begin
      acc_next = acc_q + (mcand_q * {{(XLEN-MUL_BITS_PER_CYCLE){1'b0}},
                                     mplier_q[MUL_BITS_PER_CYCLE-1:0]});
   end
`endif

   assign push_entry = '{instr: x_off_instr_i, trans_id: x_trans_id_i,
                         rs1: x_rs1_i, rs2: x_rs2_i};
   assign fifo_push       = x_issue_valid_i & ~fifo_full;
   assign x_issue_ready_o = ~fifo_full;

   fifo_v3 #(
      .DEPTH (FIFO_DEPTH),
      .dtype (resp_entry_t)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_i  (push_entry),
      .push_i  (fifo_push),
      .data_o  (head),
      .pop_i   (fifo_pop)
   );

   // An entry popped during RESP is parked in cur_q and dispatched from IDLE
   // on the following cycle, so 1-cycle ops stream one result every 2 cycles.
   assign src = pend_q ? cur_q : head;

   // Pop the head when IDLE has nothing parked, or while a result is presented.
   always_comb begin
      fifo_pop = 1'b0;
      case (state_q)
         IDLE:    fifo_pop = ~pend_q & ~fifo_empty;
         RESP:    fifo_pop = ~fifo_empty;
         default: fifo_pop = 1'b0;
      endcase
   end

   // Dispatch / execute / respond sequencer with registered result outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         pend_q   <= 1'b0;
         cur_q    <= '0;
         valid_q  <= 1'b0;
         id_q     <= '0;
         res_q    <= '0;
`ifdef CVXIF_RESP_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
`endif
      end else if (flush_i) begin
         state_q  <= IDLE;
         pend_q   <= 1'b0;
         valid_q  <= 1'b0;
`ifdef CVXIF_RESP_MUL_EN
         cnt_q    <= '0;
`endif
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pend_q || !fifo_empty) begin
                  pend_q <= 1'b0;
                  id_q   <= src.trans_id;
`ifdef CVXIF_RESP_MUL_EN
                  if (is_cmul(src.instr)) begin
                     mcand_q  <= src.rs1;
                     mplier_q <= src.rs2;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                     state_q  <= EXEC;
                  end else
`endif
                  begin
                     res_q   <= exec_single(src.instr, src.rs1, src.rs2);
                     valid_q <= 1'b1;
                     state_q <= RESP;
                  end
               end
            end
`ifdef CVXIF_RESP_MUL_EN
            EXEC: begin
               acc_q    <= acc_next;
               mcand_q  <= mcand_q << MUL_BITS_PER_CYCLE;
               mplier_q <= mplier_q >> MUL_BITS_PER_CYCLE;
               if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                  res_q   <= '{data: acc_next, we: 1'b1, ex: '0};
                  valid_q <= 1'b1;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif
            RESP: begin
               if (!fifo_empty) begin
                  cur_q  <= head;
                  pend_q <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign x_result_valid_o = valid_q & ~flush_i;
   assign x_result_id_o    = id_q;
   assign x_result_data_o  = res_q.data;
   assign x_result_we_o    = res_q.we;
   assign x_result_ex_o    = res_q.ex;

endmodule

// File: tb/tb_cvxif_issue_responder.sv
// Self-checking bench for cvxif_issue_responder: transaction-level reference
// model (queue + due-cycle scheduling) compared every cycle, plus directed cases.
module tb_cvxif_issue_responder;
   import cvxif_resp_pkg::*;

`ifdef CVXIF_RESP_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   localparam int MUL_CYCLES = 64 / 2;
   localparam int QDEPTH     = 4;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] instr = '0;
   logic [2:0]  id = '0;
   logic [63:0] rs1 = '0, rs2 = '0;
   logic        x_issue_ready_o, x_result_valid_o, x_result_we_o;
   logic [2:0]  x_result_id_o;
   logic [63:0] x_result_data_o;
   exception_t  x_result_ex_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   cvxif_issue_responder #(.FIFO_DEPTH(4), .MUL_BITS_PER_CYCLE(2)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
      .x_issue_valid_i(valid), .x_issue_ready_o(x_issue_ready_o),
      .x_off_instr_i(instr), .x_trans_id_i(id), .x_rs1_i(rs1), .x_rs2_i(rs2),
      .x_result_valid_o(x_result_valid_o), .x_result_id_o(x_result_id_o),
      .x_result_data_o(x_result_data_o), .x_result_we_o(x_result_we_o),
      .x_result_ex_o(x_result_ex_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Architectural meaning of one instruction, and its result latency counted
   // from the cycle the engine picks it up.
   function automatic void ref_exec(input logic [31:0] ins, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] d,
                                    output logic we, output logic exv,
                                    output logic [63:0] cause, output logic [63:0] tval,
                                    output int lat);
      logic legal;
      d = '0; we = 1'b0; exv = 1'b0; cause = '0; tval = '0; lat = 1;
      legal = (ins[6:0] == 7'h0B) && (ins[31:25] == 7'h00);
      if (legal && ins[14:12] == 3'd0) begin
         d = a + b; we = 1'b1;
      end else if (legal && ins[14:12] == 3'd1) begin
         we = 1'b0;
      end else if (MUL_EN && legal && ins[14:12] == 3'd2) begin
         d = a * b; we = 1'b1; lat = 1 + MUL_CYCLES;
      end else begin
         exv = 1'b1; cause = 64'd2; tval = {32'h0, ins};
      end
   endfunction

   typedef struct {
      logic [31:0] ins;
      logic [2:0]  tid;
      logic [63:0] a;
      logic [63:0] b;
   } txn_t;

   txn_t       q[$];
   txn_t       infl_e;
   bit         infl = 1'b0;
   int         due = 0;
   logic [2:0] ret_ids[$];

   // Reference model and per-cycle comparison of every DUT output.
   always @(negedge clk) begin
      logic        exp_ready, resp_now, exp_valid, we, exv;
      logic [63:0] d, cause, tval;
      int          lat;
      if (!rst_ni) begin
         q.delete();
         infl = 1'b0;
      end else begin
         exp_ready = (q.size() < QDEPTH);
         resp_now  = infl && (due == cyc);
         exp_valid = resp_now && !flush;
         check("ready", 64'(x_issue_ready_o), 64'(exp_ready));
         check("valid", 64'(x_result_valid_o), 64'(exp_valid));
         if (exp_valid) begin
            ref_exec(infl_e.ins, infl_e.a, infl_e.b, d, we, exv, cause, tval, lat);
            check("id", 64'(x_result_id_o), 64'(infl_e.tid));
            check("data", x_result_data_o, d);
            check("we", 64'(x_result_we_o), 64'(we));
            check("ex_valid", 64'(x_result_ex_o.valid), 64'(exv));
            check("ex_cause", x_result_ex_o.cause, cause);
            check("ex_tval", x_result_ex_o.tval, tval);
         end
         if (x_result_valid_o) ret_ids.push_back(x_result_id_o);
         if (flush) begin
            q.delete();
            infl = 1'b0;
         end else begin
            if (resp_now) infl = 1'b0;
            if (!infl && q.size() > 0) begin
               infl_e = q.pop_front();
               ref_exec(infl_e.ins, infl_e.a, infl_e.b, d, we, exv, cause, tval, lat);
               due  = cyc + lat + (resp_now ? 1 : 0);
               infl = 1'b1;
            end
            if (valid && exp_ready) q.push_back('{ins: instr, tid: id, a: rs1, b: rs2});
         end
      end
   end

   bit          stall_seen = 1'b0;
   int          r_cyc;
   logic [63:0] r_data, r_cause, r_tval;
   logic [2:0]  r_id;
   logic        r_we, r_exv;

   task automatic issue(input logic [31:0] ins, input logic [2:0] tid,
                        input logic [63:0] a, input logic [63:0] b, output int t);
      valid = 1'b1; instr = ins; id = tid; rs1 = a; rs2 = b;
      t = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (x_issue_ready_o) begin
            t = cyc;
            break;
         end
         stall_seen = 1'b1;
      end
      if (t < 0) begin
         checks++; failures++;
         $display("FAIL issue_timeout actual=ready_low required=ready_high");
      end
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic wait_result();
      r_cyc = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (x_result_valid_o) begin
            r_cyc = cyc; r_data = x_result_data_o; r_id = x_result_id_o;
            r_we = x_result_we_o; r_exv = x_result_ex_o.valid;
            r_cause = x_result_ex_o.cause; r_tval = x_result_ex_o.tval;
            break;
         end
      end
      if (r_cyc < 0) begin
         checks++; failures++;
         $display("FAIL result_timeout actual=no_valid required=valid");
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [2:0] f3;
      logic [6:0] f7, op;
      int unsigned sel;
      sel = $urandom_range(0, 7);
      f7 = 7'h00; op = 7'h0B;
      case (sel)
         0, 1, 2: f3 = 3'd0;
         3:       f3 = 3'd1;
         4, 5:    f3 = 3'd2;
         6:       f3 = 3'($urandom_range(3, 7));
         default: begin
            f3 = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) f7 = 7'($urandom_range(1, 127));
            else op = 7'h33;
         end
      endcase
      return {f7, 10'($urandom), f3, 5'($urandom), op};
   endfunction

   function automatic logic [63:0] rand_op();
      int unsigned s;
      s = $urandom_range(0, 7);
      if (s == 0) return '1;
      if (s == 1) return 64'($urandom_range(0, 15));
      return {$urandom, $urandom};
   endfunction

   initial begin
      int t, t2;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(x_result_valid_o), 64'd0);
      check("rst_id", 64'(x_result_id_o), 64'd0);
      check("rst_data", x_result_data_o, 64'd0);
      check("rst_we", 64'(x_result_we_o), 64'd0);
      check("rst_exv", 64'(x_result_ex_o.valid), 64'd0);
      check("rst_ready", 64'(x_issue_ready_o), 64'd1);
      rst_ni = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      issue(32'h0000000B, 3'd3, 64'd5, 64'd7, t);
      wait_result();
      check("cadd_lat", 64'(r_cyc), 64'(t + 2));
      check("cadd_data", r_data, 64'd12);
      check("cadd_id", 64'(r_id), 64'd3);
      check("cadd_we", 64'(r_we), 64'd1);
      check("cadd_exv", 64'(r_exv), 64'd0);
      repeat (3) @(posedge clk); #1;

      issue(32'h0000200B, 3'd4, 64'd6, 64'd7, t);
      wait_result();
`ifdef CVXIF_RESP_MUL_EN
      check("cmul_lat", 64'(r_cyc), 64'(t + 34));
      check("cmul_data", r_data, 64'd42);
      check("cmul_exv", 64'(r_exv), 64'd0);
`else
      check("cmul_lat", 64'(r_cyc), 64'(t + 2));
      check("cmul_exv", 64'(r_exv), 64'd1);
      check("cmul_cause", r_cause, 64'd2);
`endif
      repeat (3) @(posedge clk); #1;

      issue(32'h0000700B, 3'd5, 64'd1, 64'd2, t);
      wait_result();
      check("ill_exv", 64'(r_exv), 64'd1);
      check("ill_tval", r_tval, 64'h0000700B);
      check("ill_we", 64'(r_we), 64'd0);
      check("ill_data", r_data, 64'd0);
      repeat (3) @(posedge clk); #1;

      issue(32'h0000000B, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, t);
      wait_result();
      check("ovf_data", r_data, 64'd0);
      check("ovf_exv", 64'(r_exv), 64'd0);
      check("ovf_we", 64'(r_we), 64'd1);
      repeat (3) @(posedge clk); #1;

      // Asynchronous reset while a result is being presented.
      issue(32'h0000000B, 3'd1, 64'd9, 64'd9, t);
      @(negedge clk);
      @(negedge clk);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_valid", 64'(x_result_valid_o), 64'd0);
      check("arst_data", x_result_data_o, 64'd0);
      check("arst_ready", 64'(x_issue_ready_o), 64'd1);
      @(posedge clk); @(posedge clk); #1;
      rst_ni = 1'b1;
      @(posedge clk); #1;

      // Flush kills the in-flight instruction; a fresh CADD returns at +2.
      issue(32'h0000200B, 3'd2, 64'd3, 64'd3, t);
`ifdef CVXIF_RESP_MUL_EN
      repeat (4) @(posedge clk);
      #1;
`endif
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      issue(32'h0000000B, 3'd7, 64'd20, 64'd22, t2);
      wait_result();
      check("flush_next_lat", 64'(r_cyc), 64'(t2 + 2));
      check("flush_next_id", 64'(r_id), 64'd7);
      check("flush_next_data", r_data, 64'd42);
      repeat (3) @(posedge clk); #1;

      // Back-to-back CADD burst: must stall and return every tag in order once.
      ret_ids.delete();
      stall_seen = 1'b0;
      for (int i = 0; i < 10; i++) issue(32'h0000000B, 3'(i % 8), 64'(i), 64'(2 * i), t);
      repeat (40) @(posedge clk); #1;
      check("burst_stall", 64'(stall_seen), 64'd1);
      check("burst_count", 64'(ret_ids.size()), 64'd10);
      for (int i = 0; i < 10 && i < ret_ids.size(); i++)
         check("burst_order", 64'(ret_ids[i]), 64'(i % 8));

      // Randomized traffic with occasional flushes.
      for (int n = 0; n < 2500; n++) begin
         valid = ($urandom_range(0, 3) != 0);
         instr = rand_instr();
         id    = 3'($urandom);
         rs1   = rand_op();
         rs2   = rand_op();
         flush = ($urandom_range(0, 40) == 0);
         @(posedge clk); #1;
      end
      valid = 1'b0;
      flush = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
